// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle slave backed by a word-organised single-port SRAM.
// Responds after WAIT_STATES extra cycles; out-of-window or misaligned accesses terminate with err.
module wb_sram_responder #(
    parameter int          ADDR_WIDTH  = 13,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [32:0] WIN_SIZE = 33'd4 << ADDR_WIDTH;
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [31:0]             adr_q;
    logic [31:0]             dat_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [31:0]             mem [0:DEPTH-1];

    logic [31:0]             acc_adr;
    logic [31:0]             acc_dat;
    logic                    acc_we;
    logic [3:0]              acc_sel;
    logic [32:0]             offset;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    valid;
    logic                    finish;

    // With zero wait states the response edge is the same edge that samples the
    // request, so the access fields come straight from the bus while in IDLE.
    always_comb begin
        if (state == IDLE) begin
            acc_adr = wb_adr_i;
            acc_dat = wb_dat_i;
            acc_we  = wb_we_i;
            acc_sel = wb_sel_i;
        end else begin
            acc_adr = adr_q;
            acc_dat = dat_q;
            acc_we  = we_q;
            acc_sel = sel_q;
        end
    end

    // A borrow out of the subtraction makes offset huge, so one compare covers both bounds.
    assign offset = {1'b0, acc_adr} - {1'b0, BASE_ADDR};
    assign idx    = offset[ADDR_WIDTH+1:2];
    assign valid  = (offset < WIN_SIZE) && (acc_adr[1:0] == 2'b00);
    assign finish = ((state == IDLE) && wb_cyc_i && wb_stb_i && (WS == 4'd0)) ||
                    ((state == WAIT) && wb_cyc_i && (cnt == 4'd1));

    // NOTE: the array has no reset so it maps onto SRAM macros; only control state is reset.
    always_ff @(posedge clk) begin
        if (finish && valid && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) mem[idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            adr_q    <= 32'd0;
            dat_q    <= 32'd0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        adr_q <= wb_adr_i;
                        dat_q <= wb_dat_i;
                        we_q  <= wb_we_i;
                        sel_q <= wb_sel_i;
                        cnt   <= WS;
                        state <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                    cnt <= cnt - 4'd1;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (finish) begin
                if (valid) begin
                    wb_ack_o <= 1'b1;
                    if (!acc_we) wb_dat_o <= mem[idx];
                end else begin
                    wb_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_responder.sv
// Scoreboard bench for wb_sram_responder: three instances at 1, 3 and 0 wait states
// share one address/data bus and have private cyc/stb.
module tb_wb_sram_responder;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] WIN  = 32'd4 << AW;

    typedef struct {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] adr   = '0;
    logic [31:0] wdat  = '0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = '0;
    logic [2:0]  cyc   = '0;
    logic [2:0]  stb   = '0;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] rdat [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat[0]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]));

    wb_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat[1]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]));

    wb_sram_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat[2]),
        .wb_we_i(we), .wb_sel_i(sel), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
        .wb_ack_o(ack[2]), .wb_err_o(err[2]));

    // One bus transaction on instance u: the expectation is queued as the request is
    // driven, then popped and compared when the instance terminates the cycle.
    task automatic do_access(input int u, input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] s, input logic e_err,
                             input logic [31:0] e_data, input int e_lat);
        exp_t ex;
        int   k;
        logic got;
        sb.push_back('{e_err, !w, e_data, e_lat});
        @(posedge clk); #1;
        adr = a; wdat = d; we = w; sel = s; cyc[u] = 1'b1; stb[u] = 1'b1;
        got = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[u] || err[u]) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
        end
        ex = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL access_timeout u=%0d adr=%h: no response within 20 cycles", u, a);
        end else begin
            if (k !== ex.lat) begin
                errors++;
                $display("FAIL latency u=%0d adr=%h: got cycle %0d, want %0d", u, a, k, ex.lat);
            end
            checks++;
            if (ack[u] !== !ex.is_err || err[u] !== ex.is_err) begin
                errors++;
                $display("FAIL termination u=%0d adr=%h: ack=%b err=%b, want err=%b",
                         u, a, ack[u], err[u], ex.is_err);
            end
            if (ex.chk_data) begin
                checks++;
                if (rdat[u] !== ex.data) begin
                    errors++;
                    $display("FAIL read_data u=%0d adr=%h: got %h, want %h", u, a, rdat[u], ex.data);
                end
            end
        end
        @(posedge clk); #1;
        cyc[u] = 1'b0; stb[u] = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (ack[u] !== 1'b0 || err[u] !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle u=%0d adr=%h: ack=%b err=%b after response", u, a, ack[u], err[u]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (ack[u] !== 1'b0 || err[u] !== 1'b0 || rdat[u] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state u=%0d: ack=%b err=%b dat=%h, want 0/0/0",
                         u, ack[u], err[u], rdat[u]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        do_access(0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 32'd0, 2);
        do_access(0, BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, 32'hDEAD_BEEF, 2);
    endtask

    task automatic test_byte_lanes;
        do_access(0, BASE + 32'h10, 32'h1122_3344, 1'b1, 4'b0101, 1'b0, 32'd0, 2);
        do_access(0, BASE + 32'h10, 32'd0, 1'b0, 4'b0000, 1'b0, 32'hDE22_BE44, 2);
    endtask

    task automatic test_errors;
        do_access(0, BASE + WIN, 32'd0, 1'b0, 4'hF, 1'b1, 32'hDE22_BE44, 2);
        do_access(0, BASE - 32'd4, 32'd0, 1'b0, 4'hF, 1'b1, 32'hDE22_BE44, 2);
        do_access(0, BASE, 32'h0123_4567, 1'b1, 4'hF, 1'b0, 32'd0, 2);
        do_access(0, BASE + 32'h2, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b1, 32'd0, 2);
        do_access(0, BASE, 32'd0, 1'b0, 4'hF, 1'b0, 32'h0123_4567, 2);
        do_access(0, BASE + WIN - 32'd4, 32'h89AB_CDEF, 1'b1, 4'hF, 1'b0, 32'd0, 2);
        do_access(0, BASE + WIN - 32'd4, 32'd0, 1'b0, 4'hF, 1'b0, 32'h89AB_CDEF, 2);
    endtask

    task automatic test_abort;
        logic seen;
        do_access(1, BASE + 32'h30, 32'h5A5A_0000, 1'b1, 4'hF, 1'b0, 32'd0, 4);
        @(posedge clk); #1;
        adr = BASE + 32'h30; wdat = 32'hA5A5_A5A5; we = 1'b1; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc[1] = 1'b0; stb[1] = 1'b0; we = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1] || err[1]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_response: got a termination after cyc dropped, want none");
        end
        do_access(1, BASE + 32'h30, 32'd0, 1'b0, 4'hF, 1'b0, 32'h5A5A_0000, 4);
    endtask

    task automatic test_reset_mid_wait;
        do_access(1, BASE + 32'h20, 32'h0BAD_F00D, 1'b1, 4'hF, 1'b0, 32'd0, 4);
        do_access(1, BASE + 32'h20, 32'd0, 1'b0, 4'hF, 1'b0, 32'h0BAD_F00D, 4);
        @(posedge clk); #1;
        adr = BASE + 32'h20; wdat = 32'hFFFF_FFFF; we = 1'b1; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ack=%b err=%b dat=%h, want 0/0/0", ack[1], err[1], rdat[1]);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1, BASE + 32'h20, 32'd0, 1'b0, 4'hF, 1'b0, 32'h0BAD_F00D, 4);
    endtask

    task automatic test_back_to_back;
        exp_t ex;
        int   n;
        logic prev;
        for (int i = 0; i < 4; i++)
            do_access(2, BASE + 32'h40 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h1111),
                      1'b1, 4'hF, 1'b0, 32'd0, 1);
        @(posedge clk); #1;
        adr = BASE + 32'h40; we = 1'b0; sel = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
        for (int i = 0; i < 4; i++)
            sb.push_back('{1'b0, 1'b1, 32'hC0DE_0000 + 32'(i * 32'h1111), 2 * i + 1});
        n = 0;
        prev = 1'b0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            if (err[2]) begin
                checks++;
                errors++;
                $display("FAIL b2b_err: err asserted in cycle %0d", c);
            end
            if (ack[2]) begin
                ex = sb.pop_front();
                checks++;
                if (c !== ex.lat) begin
                    errors++;
                    $display("FAIL b2b_latency read %0d: got cycle %0d, want %0d", n, c, ex.lat);
                end
                checks++;
                if (rdat[2] !== ex.data) begin
                    errors++;
                    $display("FAIL b2b_data read %0d: got %h, want %h", n, rdat[2], ex.data);
                end
                checks++;
                if (prev) begin
                    errors++;
                    $display("FAIL b2b_double_ack: ack high in cycles %0d and %0d", c - 1, c);
                end
                n++;
                adr = BASE + 32'h40 + 32'(4 * n);
            end
            prev = ack[2];
            if (n == 4) begin
                cyc[2] = 1'b0; stb[2] = 1'b0;
            end
            @(posedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d acks, want 4", n);
            cyc[2] = 1'b0; stb[2] = 1'b0;
            sb.delete();
        end
        @(negedge clk);
        checks++;
        if (ack[2] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_trailing_ack: ack=%b after last read, want 0", ack[2]);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_abort();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sram_responder.md
# wb_sram_responder

Wishbone classic-cycle slave that answers the SoC CPU's instruction and data bus masters with single-port, word-organised on-chip SRAM. It gives a configurable number of wait states, per-byte write enables, and an error response for accesses that are out of range or misaligned. One instance serves as instruction ROM/RAM and one as data RAM behind the SoC address decoder.

## Interface
Parameters:
- `ADDR_WIDTH`, 13: word-address bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte base address of the window; must be aligned to 4·2^ADDR_WIDTH.
- `WAIT_STATES`, 1: extra cycles inserted before the response; legal range 0..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wb_adr_i`  in  32  byte address.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data.
- `wb_we_i`  in  1  1 = write.
- `wb_sel_i`  in  4  byte lane enables; bit n maps to bits [8n+7:8n].
- `wb_cyc_i`  in  1  bus cycle active.
- `wb_stb_i`  in  1  strobe.
- `wb_ack_o`  out  1  normal termination.
- `wb_err_o`  out  1  error termination.

## Operation
States and transitions:
- IDLE. When `wb_cyc_i & wb_stb_i` is high at a rising edge, the block latches the address, `we`, `sel` and write data, and loads the counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESP.
- WAIT. The counter decrements each edge.
  - When the counter reaches 1, next state is RESP.
  - If `wb_cyc_i` is low at an edge, the access is aborted: return to IDLE with no ack, no err and no write.
- RESP. `wb_ack_o` or `wb_err_o` is high for exactly this one cycle; next state is always IDLE.
  - The block does not sample a new request during RESP, so there is no double-ack on a held strobe.

Address check, evaluated on the latched address:
- The access is valid only if BASE_ADDR ≤ adr < BASE_ADDR + 4·2^ADDR_WIDTH and adr[1:0] == 0.
- Invalid access: err instead of ack, no memory write, and `wb_dat_o` is unchanged.

Memory behaviour:
- Word index = (adr − BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits.
- Write: performed on the edge entering RESP. Only lanes with `sel` set are updated. `sel` = 0 still returns ack and changes nothing.
- Read: the array word is registered into `wb_dat_o` on the edge entering RESP. `wb_dat_o` holds that value until the next valid read. All 4 bytes are returned regardless of `sel`.
- `wb_ack_o` and `wb_err_o` are never high in the same cycle.

Reset:
- Asynchronous reset forces IDLE, `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0 and counter = 0.
- Memory contents are not reset. An access in flight when reset asserts is dropped, with no write.

## Timing
- Request first valid in cycle 0: response in cycle 1 + WAIT_STATES, lasting 1 cycle.
- Back-to-back with strobe held: IDLE occupies the cycle after RESP, so the next response arrives WAIT_STATES + 2 cycles after the previous one. Minimum period is 2 cycles at WAIT_STATES = 0.
- Read-after-write to the same word, back-to-back: the read returns the newly written data.
- All outputs are registered; there is no combinational path from inputs to outputs.
- The block ignores `wb_stb_i` without `wb_cyc_i`. It samples a new request only in IDLE.

## Test plan
- Reset: assert `rst_n` = 0 mid-WAIT → `wb_ack_o` = 0, `wb_err_o` = 0, `wb_dat_o` = 0 immediately, with no clock needed. The target word is unchanged after reset releases.
- Write then read at WAIT_STATES = 1: write 32'hDEADBEEF to BASE + 0x10 with sel = F, then read the same address. Ack must occur in cycle 2 of each access, and the read returns 32'hDEADBEEF.
- Byte lanes: after the above, write 32'h11223344 with sel = 4'b0101, then read → 32'hDE22BE44.
- Errors:
  - Read at BASE + 4·2^ADDR_WIDTH → err for 1 cycle, no ack, `wb_dat_o` holds its old value.
  - Write to BASE + 0x2 → err, and memory is unchanged.
- Abort: drop `wb_cyc_i` in WAIT with WAIT_STATES = 3 during a write of 32'hA5A5A5A5 → no ack, no err, and a subsequent read returns the old value.
- Back-to-back at WAIT_STATES = 0: four reads with strobe held continuously → acks in cycles 1, 3, 5 and 7, each carrying the correct word, and never two consecutive ack cycles.
